// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: registered one-hot grant, bounded hold time and one-cycle turnaround.
// Define RR_GRANT_ASSERT_EN to compile immediate grant-integrity assertions.
module rr_grant_ctrl #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            timeout_q, timeout_d;

    logic            pickValid;
    logic [IW-1:0]   pickIdx;
    logic [IW:0]     candSum;
    logic [IW-1:0]   cand;

    // Search upward from ptr, wrapping at N; the sum is one bit wider so the wrap can be detected.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        candSum   = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            candSum = {1'b0, ptr_q} + (IW+1)'(i);
            if (candSum >= (IW+1)'(N)) begin
                candSum = candSum - (IW+1)'(N);
            end
            cand = candSum[IW-1:0];
            if (!pickValid && req[cand]) begin
                pickValid = 1'b1;
                pickIdx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pickValid) begin
                    state_d          = GRANT;
                    gnt_d            = '0;
                    gnt_d[pickIdx]   = 1'b1;
                    owner_d          = pickIdx;
                    hold_d           = HW'(1);
                end
            end
            GRANT: begin
                // A release on the limit cycle wins over preemption, so no timeout pulse then.
                if (!req[owner_q]) begin
                    state_d = TURN;
                    gnt_d   = '0;
                end else if (hold_q == HW'(MAX_HOLD)) begin
                    state_d   = TURN;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            TURN: begin
                state_d = IDLE;
                ptr_d   = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign busy    = |gnt_q;
    assign timeout = timeout_q;

`ifdef RR_GRANT_ASSERT_EN
    always @(posedge clock) begin
        if (reset_n) begin
            assert ($onehot0(gnt_q))
                else $error("[%0t] gnt not one-hot: gnt=%b", $time, gnt_q);
            assert (busy == |gnt_q)
                else $error("[%0t] busy disagrees with gnt: gnt=%b", $time, gnt_q);
            if (state_q == TURN) begin
                assert (gnt_q == '0)
                    else $error("[%0t] gnt active in TURN: gnt=%b", $time, gnt_q);
            end
            if (timeout_q) begin
                assert (gnt_q == '0)
                    else $error("[%0t] gnt active with timeout: gnt=%b", $time, gnt_q);
            end
            if (state_q == GRANT) begin
                assert (gnt_q == ({{(N-1){1'b0}}, 1'b1} << owner_q))
                    else $error("[%0t] gnt does not match owner: gnt=%b", $time, gnt_q);
            end
        end
    end
`else
    // Default build carries no checking logic.
`endif

endmodule
